// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: buffer entry, FSM encoding, reset PC default.
package fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry FIFO of fetched instructions; flush wins over a same-cycle push.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    push,
  input  fetch_entry_t            push_entry,
  input  logic                    pop,
  output fetch_entry_t            head,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_entry;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_r + {{AW{1'b0}}, do_push_s} - {{AW{1'b0}}, do_pop_s};
    end
  end

  assign head      = mem_r[rd_ptr_r];
  assign occupancy = count_r;
  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == CNT_ZERO);

endmodule

// File: rtl/fetch_chk.sv
// Simulation checker: memory must never answer when nothing is in flight.
module fetch_chk #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          reset_n,
  input logic          imem_rsp_valid,
  input logic [CW-1:0] inflight
);

  rsp_needs_request: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rsp_valid |-> (inflight != '0))
    else $error("imem response arrived with no request in flight");

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: credit-limited imem requests, in-order response buffer, redirect squash.
// Optional perf counters (perf_fetched, perf_squashed) when FETCH_PERF_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_data
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW:0]   CREDIT_LIM = (CW + 1)'(DEPTH);
  localparam logic [31:0]   PC_STEP    = 32'd4;

  fetch_state_e  state_r, next_state_s;
  logic [31:0]   fetch_pc_r, rsp_pc_r, target_s;
  logic [CW-1:0] inflight_r, squash_cnt_r, inflight_next_s, squash_next_s, occupancy_s;
  logic [CW:0]   load_s;
  logic          run_r, credit_s, req_hs_s, rsp_s, drop_s, push_s, pop_s, full_s, empty_s;
  fetch_entry_t  head_s, push_entry_s;

  assign target_s = word_align(redirect_pc);
  assign pop_s    = instr_valid && instr_ready;
  // A same-cycle pop frees a slot, which is what sustains one fetch per cycle.
  assign load_s   = {1'b0, inflight_r} + {1'b0, occupancy_s} - {{CW{1'b0}}, pop_s};
  assign credit_s = (load_s < CREDIT_LIM);

  assign imem_req_valid  = run_r && (state_r == FETCH) && credit_s;
  assign imem_req_addr   = fetch_pc_r;
  assign req_hs_s        = imem_req_valid && imem_req_ready;
  assign rsp_s           = imem_rsp_valid && (inflight_r != CNT_ZERO);
  assign drop_s          = rsp_s && (redirect_valid || (squash_cnt_r != CNT_ZERO));
  assign push_s          = rsp_s && !drop_s;
  assign push_entry_s    = '{pc: rsp_pc_r, data: imem_rsp_data};
  assign inflight_next_s = inflight_r + {{(CW-1){1'b0}}, req_hs_s} - {{(CW-1){1'b0}}, rsp_s};

  // squash bookkeeping and FETCH/DRAIN transitions
  always_comb begin
    squash_next_s = squash_cnt_r;
    next_state_s  = state_r;
    if (redirect_valid) begin
      squash_next_s = inflight_next_s;
    end else if (drop_s) begin
      squash_next_s = squash_cnt_r - CNT_ONE;
    end else begin
      squash_next_s = squash_cnt_r;
    end
    case (state_r)
      FETCH: begin
        if (redirect_valid && (squash_next_s != CNT_ZERO)) next_state_s = DRAIN;
        else next_state_s = FETCH;
      end
      DRAIN: begin
        if (squash_next_s != CNT_ZERO) next_state_s = DRAIN;
        else next_state_s = FETCH;
      end
      default: next_state_s = FETCH;
    endcase
  end

  // state, PCs and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= FETCH;
      run_r        <= 1'b0;
      fetch_pc_r   <= RESET_PC;
      rsp_pc_r     <= RESET_PC;
      inflight_r   <= CNT_ZERO;
      squash_cnt_r <= CNT_ZERO;
    end else begin
      state_r      <= next_state_s;
      run_r        <= 1'b1;
      inflight_r   <= inflight_next_s;
      squash_cnt_r <= squash_next_s;
      if (redirect_valid) begin
        fetch_pc_r <= target_s;
        rsp_pc_r   <= target_s;
      end else begin
        if (req_hs_s) fetch_pc_r <= fetch_pc_r + PC_STEP;
        if (push_s) rsp_pc_r <= rsp_pc_r + PC_STEP;
      end
    end
  end

  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .occupancy  (occupancy_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  assign instr_valid = !empty_s;
  assign instr_pc    = head_s.pc;
  assign instr_data  = head_s.data;

  fetch_chk #(.CW(CW)) u_chk (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_rsp_valid (imem_rsp_valid),
    .inflight       (inflight_r)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] flushed_s;
  assign flushed_s = redirect_valid ? 32'(occupancy_s - {{(CW-1){1'b0}}, pop_s}) : 32'd0;

  // delivered and squashed instruction counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched  <= 32'd0;
      perf_squashed <= 32'd0;
    end else begin
      perf_fetched  <= perf_fetched + {31'd0, pop_s};
      perf_squashed <= perf_squashed + {31'd0, drop_s} + flushed_s;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: random memory latency/backpressure/redirects, scoreboard of expected instructions.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        instr_valid, instr_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, instr_pc, instr_data;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif

  always #5 clk = ~clk;

  fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_pc(instr_pc), .instr_data(instr_data)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  mem_req_t     pending[$];
  fetch_entry_t exp_q[$];

  int errors = 0, checks = 0, cyc = 0;
  int lat_lo = 1, lat_hi = 1, last_due, model_inflight, squash_pend, issued, pops;
  int first_hs_cyc, first_iv_cyc;
  logic [31:0] exp_fetch_pc, redir_tgt, prev_ipc, prev_idata, prev_addr;
  logic chk_redir, prev_iv_stall, prev_req_stall;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    pending.delete(); exp_q.delete();
    exp_fetch_pc = RST_PC; model_inflight = 0; squash_pend = 0; issued = 0; pops = 0;
    last_due = 0; first_hs_cyc = -1; first_iv_cyc = -1;
    chk_redir = 1'b0; prev_iv_stall = 1'b0; prev_req_stall = 1'b0;
  endtask

  // advance one cycle and let the memory model answer in order
  task automatic tick();
    @(posedge clk); #1; cyc++;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check32({tag, "_req_addr"}, imem_req_addr, RST_PC);
    check32({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check32({tag, "_instr_pc"}, instr_pc, 32'd0);
    check32({tag, "_instr_data"}, instr_data, 32'd0);
  endtask

  task automatic wait_inflight2();
    int i;
    for (i = 0; i < 60 && !(model_inflight == 2 && !imem_rsp_valid); i++) tick();
    if (i == 60) begin checks++; errors++; $display("FAIL inflight_wait: got %0d, expected 2", model_inflight); end
  endtask

  task automatic wait_delivery(input string name);
    int i;
    for (i = 0; i < 80 && chk_redir; i++) tick();
    if (chk_redir) begin checks++; errors++; $display("FAIL %s_timeout: got none, expected pc 0x%h", name, redir_tgt); end
  endtask

  // monitor: compare each delivered instruction with the scoreboard
  always @(negedge clk) begin
    fetch_entry_t e;
    if (reset_n) begin
      if (prev_iv_stall) begin
        check32("instr_hold_valid", {31'd0, instr_valid}, 32'd1);
        check32("instr_hold_pc", instr_pc, prev_ipc);
        check32("instr_hold_data", instr_data, prev_idata);
      end
      if (instr_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
      if (instr_valid && instr_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr: got pc 0x%h, expected no instruction", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check32("instr_pc", instr_pc, e.pc);
          check32("instr_data", instr_data, e.data);
        end
        if (chk_redir) begin
          check32("redirect_first_pc", instr_pc, redir_tgt);
          chk_redir = 1'b0;
        end
      end
      prev_iv_stall = instr_valid && !instr_ready && !redirect_valid;
      prev_ipc      = instr_pc;
      prev_idata    = instr_data;
    end
  end

  // reference model: memory queue, squash accounting, expected instruction stream
  always @(negedge clk) begin
    logic hs, rsp, redir;
    logic [31:0] addr, tgt;
    int post, due;
    if (reset_n) begin
      hs = imem_req_valid && imem_req_ready;
      rsp = imem_rsp_valid; redir = redirect_valid;
      addr = imem_req_addr; tgt = {redirect_pc[31:2], 2'b00};
      if (prev_req_stall) begin
        check32("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
        check32("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (hs) begin
        check32("req_addr", addr, exp_fetch_pc);
        check32("req_in_drain", 32'(squash_pend), 32'd0);
      end
      prev_req_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr = imem_req_addr;
      #1;
      post = model_inflight + (hs ? 1 : 0) - (rsp ? 1 : 0);
      if (hs) begin
        due = cyc + int'($urandom_range(lat_lo, lat_hi));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pending.push_back('{addr, due});
        issued++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
      end
      if (redir) begin
        exp_q.delete();
        exp_fetch_pc = tgt; redir_tgt = tgt; chk_redir = 1'b1;
        squash_pend = post;
      end else begin
        if (rsp && squash_pend > 0) squash_pend--;
        if (hs) begin
          exp_q.push_back('{pc: exp_fetch_pc, data: memf(exp_fetch_pc)});
          exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
      end
      model_inflight = post;
    end
  end

  initial begin
    int p0, i;
    reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; instr_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst");

    // steady fetch at latency 1
    tick(); reset_n = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    for (i = 0; i < 50 && first_iv_cyc < 0; i++) tick();
    check32("first_instr_latency", 32'(first_iv_cyc - first_hs_cyc), 32'd2);
    repeat (10) tick();
    p0 = pops;
    repeat (20) tick();
    check32("throughput", 32'(pops - p0), 32'd20);

    // decode stall: buffer fills, requests stop, nothing lost on release
    instr_ready = 1'b0;
    repeat (10) tick();
    check32("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check32("stall_outstanding", 32'(exp_q.size()), 32'(DEPTH));
    instr_ready = 1'b1;
    repeat (10) tick();

    // redirect with two requests in flight
    lat_lo = 3; lat_hi = 3;
    wait_inflight2();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick(); redirect_valid = 1'b0;
    wait_delivery("redir_100");

    // redirect coinciding with a request handshake and a response
    lat_lo = 1; lat_hi = 1;
    repeat (8) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick(); redirect_valid = 1'b0;
    wait_delivery("redir_203");

    // back-to-back redirects while draining
    lat_lo = 3; lat_hi = 3;
    wait_inflight2();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick(); redirect_pc = 32'h0000_0080;
    tick(); redirect_valid = 1'b0;
    wait_delivery("redir_80");

    // random traffic
    lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 1500; n++) begin
      tick();
      instr_ready    = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 9) < 8);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom;
    end
    redirect_valid = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1;
    repeat (20) tick();

    // asynchronous reset in the middle of a burst
    lat_lo = 1; lat_hi = 1;
    repeat (6) tick();
    @(posedge clk); #3;
    reset_n = 1'b0; imem_rsp_valid = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_clear();
    repeat (2) @(posedge clk);
    tick(); reset_n = 1'b1;
    for (i = 0; i < 50 && first_iv_cyc < 0; i++) tick();
    check32("restart_latency", 32'(first_iv_cyc - first_hs_cyc), 32'd2);
    repeat (20) tick();
    check32("outstanding_bound", {31'd0, exp_q.size() <= DEPTH}, 32'd1);

`ifdef FETCH_PERF_EN
    check32("perf_fetched", perf_fetched, 32'(pops));
    check32("perf_squashed", perf_squashed, 32'(issued - pops - exp_q.size() - squash_pend));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
